// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle for the execute stage.
// master: upstream/downstream side (drives ID/EX fields, sees stall and EX/MEM).
// slave : the execute stage itself.
interface ex_stage_if;
  logic        in_valid;
  logic        WriteReg;
  logic        MemToReg;
  logic        WriteMem;
  logic        MemRead;
  logic        Branch;
  logic        ALUSrc;
  logic [3:0]  ALUop;
  logic [31:0] pc_plus4;
  logic [31:0] Adat;
  logic [31:0] Bdat;
  logic [31:0] imm;
  logic [4:0]  regW;
  logic        flush;
  logic        stall;
  logic        valid_out;
  logic        WriteRegout;
  logic        MemToRegout;
  logic        WriteMemout;
  logic        MemReadout;
  logic        Branchout;
  logic [31:0] pcplusimm;
  logic        zero;
  logic [31:0] oALU;
  logic [31:0] Bdatout;
  logic [4:0]  regWout;

  modport master (
    output in_valid, WriteReg, MemToReg, WriteMem, MemRead, Branch, ALUSrc,
           ALUop, pc_plus4, Adat, Bdat, imm, regW, flush,
    input  stall, valid_out, WriteRegout, MemToRegout, WriteMemout, MemReadout,
           Branchout, pcplusimm, zero, oALU, Bdatout, regWout
  );

  modport slave (
    input  in_valid, WriteReg, MemToReg, WriteMem, MemRead, Branch, ALUSrc,
           ALUop, pc_plus4, Adat, Bdat, imm, regW, flush,
    output stall, valid_out, WriteRegout, MemToRegout, WriteMemout, MemReadout,
           Branchout, pcplusimm, zero, oALU, Bdatout, regWout
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand select, ALU, branch target, EX/MEM register and a
// 32-step shift-add multiplier that stalls upstream while it iterates.
//
// state | meaning
// IDLE  | accepting instructions; single-cycle ops complete here
// BUSY  | multiplier iterating, one shift-add step per cycle, stall high
// DONE  | product ready; EX/MEM takes the latched MUL, upstream released
module ex_stage (
  input logic     clk,
  input logic     rst_n,
  ex_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] OP_MUL = 4'd12;

  state_t      r_state, w_state_nxt;
  logic        w_stall, w_mul_start;
  logic [31:0] w_a, w_b, w_alu;

  logic [4:0]  r_cnt;
  logic [31:0] r_mcand, r_mplier, r_acc;
  logic [4:0]  r_l_ctrl;
  logic [4:0]  r_l_regw;
  logic [31:0] r_l_bdat, r_l_pc4, r_l_imm;

  logic        r_valid;
  logic [4:0]  r_ctrl;
  logic [31:0] r_target, r_alu, r_bdat;
  logic        r_zero;
  logic [4:0]  r_regw;

  assign w_a = bus.Adat;
  assign w_b = bus.ALUSrc ? bus.imm : bus.Bdat;

  // Single-cycle ALU; MUL never uses this path, so its slot is don't-care.
  always_comb begin
    w_alu = w_a + w_b;
    case (bus.ALUop)
      4'd1:    w_alu = w_a - w_b;
      4'd2:    w_alu = w_a & w_b;
      4'd3:    w_alu = w_a | w_b;
      4'd4:    w_alu = w_a ^ w_b;
      4'd5:    w_alu = ~(w_a | w_b);
      4'd6:    w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
      4'd7:    w_alu = {31'd0, w_a < w_b};
      4'd8:    w_alu = w_b << w_a[4:0];
      4'd9:    w_alu = w_b >> w_a[4:0];
      4'd10:   w_alu = $unsigned($signed(w_b) >>> w_a[4:0]);
      4'd11:   w_alu = {w_b[15:0], 16'd0};
      default: w_alu = w_a + w_b;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and stall; flush overrides everything and drops stall.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_mul_start = 1'b0;
    if (bus.flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid && bus.ALUop == OP_MUL) begin
          w_stall     = 1'b1;
          w_mul_start = 1'b1;
          w_state_nxt = BUSY;
        end
        BUSY: begin
          w_stall = 1'b1;
          if (r_cnt == 5'd31) w_state_nxt = DONE;
        end
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Stall is held low while reset is asserted, whatever the inputs show.
  assign bus.stall = w_stall & rst_n;

  // Multiplier operands, step counter and latched copy of the MUL's fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_l_ctrl <= '0;
      r_l_regw <= '0;
      r_l_bdat <= '0;
      r_l_pc4  <= '0;
      r_l_imm  <= '0;
    end else if (bus.flush) begin
      r_cnt <= '0;
    end else if (w_mul_start) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= w_a;
      r_mplier <= w_b;
      r_l_ctrl <= {bus.WriteReg, bus.MemToReg, bus.WriteMem, bus.MemRead, bus.Branch};
      r_l_regw <= bus.regW;
      r_l_bdat <= bus.Bdat;
      r_l_pc4  <= bus.pc_plus4;
      r_l_imm  <= bus.imm;
    end else if (r_state == BUSY) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 5'd1;
    end
  end

  // EX/MEM register: bubble unless a single-cycle op completes or MUL is done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_target <= '0;
      r_alu    <= '0;
      r_zero   <= 1'b0;
      r_bdat   <= '0;
      r_regw   <= '0;
    end else begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_target <= '0;
      r_alu    <= '0;
      r_zero   <= 1'b0;
      r_bdat   <= '0;
      r_regw   <= '0;
      if (!bus.flush) begin
        if (r_state == IDLE && bus.in_valid && bus.ALUop != OP_MUL) begin
          r_valid  <= 1'b1;
          r_ctrl   <= {bus.WriteReg, bus.MemToReg, bus.WriteMem, bus.MemRead, bus.Branch};
          r_target <= bus.pc_plus4 + (bus.imm << 2);
          r_alu    <= w_alu;
          r_zero   <= (w_alu == 32'd0);
          r_bdat   <= bus.Bdat;
          r_regw   <= bus.regW;
        end else if (r_state == DONE) begin
          r_valid  <= 1'b1;
          r_ctrl   <= r_l_ctrl;
          r_target <= r_l_pc4 + (r_l_imm << 2);
          r_alu    <= r_acc;
          r_zero   <= (r_acc == 32'd0);
          r_bdat   <= r_l_bdat;
          r_regw   <= r_l_regw;
        end
      end
    end
  end

  assign bus.valid_out   = r_valid;
  assign bus.WriteRegout = r_ctrl[4];
  assign bus.MemToRegout = r_ctrl[3];
  assign bus.WriteMemout = r_ctrl[2];
  assign bus.MemReadout  = r_ctrl[1];
  assign bus.Branchout   = r_ctrl[0];
  assign bus.pcplusimm   = r_target;
  assign bus.zero        = r_zero;
  assign bus.oALU        = r_alu;
  assign bus.Bdatout     = r_bdat;
  assign bus.regWout     = r_regw;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, branch target, iterative MUL timing,
// flush and back-to-back MULs, all against hand-computed values.
module tb_ex_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  ex_stage_if bus ();

  ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ctl = {WriteReg, MemToReg, WriteMem, MemRead, Branch}
  task automatic set_in(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im, input logic src,
                        input logic [4:0] ctl, input logic [31:0] pc4, input logic [4:0] rw);
    bus.in_valid = v;
    bus.ALUop    = op;
    bus.Adat     = a;
    bus.Bdat     = b;
    bus.imm      = im;
    bus.ALUSrc   = src;
    {bus.WriteReg, bus.MemToReg, bus.WriteMem, bus.MemRead, bus.Branch} = ctl;
    bus.pc_plus4 = pc4;
    bus.regW     = rw;
  endtask

  task automatic idle_in();
    set_in(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
  endtask

  task automatic alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    set_in(1'b1, op, a, b, 32'd0, 1'b0, 5'b10000, 32'd0, 5'd1);
    tick();
    chk(tag, bus.oALU, exp);
  endtask

  // Issue one MUL and follow it to its result; upstream advances on the DONE edge.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic src, input logic [4:0] rw,
                         input logic [31:0] exp, input logic expz);
    int n;
    int bub;
    set_in(1'b1, 4'd12, a, b, im, src, 5'b10000, 32'h40, rw);
    #1;
    n = 0;
    bub = 0;
    while (bus.stall && n < 40) begin
      n++;
      tick();
      if (!bus.valid_out && bus.oALU == 32'd0) bub++;
    end
    chk({tag, "_stall_cycles"}, n, 33);
    chk({tag, "_bubbles"}, bub, 33);
    idle_in();
    tick();
    chk({tag, "_valid"}, {31'd0, bus.valid_out}, 32'd1);
    chk({tag, "_oALU"}, bus.oALU, exp);
    chk({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, expz});
    chk({tag, "_regW"}, {27'd0, bus.regWout}, {27'd0, rw});
    chk({tag, "_bdat"}, bus.Bdatout, b);
    chk({tag, "_target"}, bus.pcplusimm, 32'h40 + (im << 2));
  endtask

  initial begin
    int vcnt;
    int idx;
    int nres;
    logic st;
    int          res_edge[3];
    logic [31:0] res_alu[3];
    logic [4:0]  res_rw[3];
    logic [3:0]  b2b_op[3];
    logic [31:0] b2b_a[3];
    logic [31:0] b2b_b[3];
    logic [4:0]  b2b_rw[3];

    bus.flush = 1'b0;
    idle_in();
    tick();
    tick();
    chk("rst_valid", {31'd0, bus.valid_out}, 32'd0);
    chk("rst_oALU", bus.oALU, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);

    rst_n = 1'b1;
    set_in(1'b1, 4'd0, 32'd3, 32'd4, 32'd0, 1'b0, 5'b10000, 32'd0, 5'd3);
    tick();
    chk("add_first", bus.oALU, 32'd7);
    chk("add_first_valid", {31'd0, bus.valid_out}, 32'd1);
    chk("add_first_regW", {27'd0, bus.regWout}, 32'd3);

    // Mid-stream reset with a MUL presented: outputs clear at once, no stall.
    alu("add_pre_rst", 4'd0, 32'd10, 32'd20, 32'd30);
    set_in(1'b1, 4'd12, 32'd2, 32'd2, 32'd0, 1'b0, 5'b10000, 32'd0, 5'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, bus.valid_out}, 32'd0);
    chk("midrst_oALU", bus.oALU, 32'd0);
    chk("midrst_wreg", {31'd0, bus.WriteRegout}, 32'd0);
    chk("midrst_stall", {31'd0, bus.stall}, 32'd0);
    set_in(1'b1, 4'd0, 32'd3, 32'd4, 32'd0, 1'b0, 5'b10000, 32'd0, 5'd3);
    #1;
    rst_n = 1'b1;
    tick();
    chk("add_after_rst", bus.oALU, 32'd7);

    // Branch compare and target.
    set_in(1'b1, 4'd1, 32'd5, 32'd5, 32'd3, 1'b0, 5'b00001, 32'h100, 5'd0);
    tick();
    chk("br_zero", {31'd0, bus.zero}, 32'd1);
    chk("br_target", bus.pcplusimm, 32'h10C);
    chk("br_branchout", {31'd0, bus.Branchout}, 32'd1);
    chk("br_wreg", {31'd0, bus.WriteRegout}, 32'd0);

    // ALU sweep.
    alu("slt", 4'd6, 32'hFFFFFFFF, 32'd1, 32'd1);
    alu("sltu", 4'd7, 32'hFFFFFFFF, 32'd1, 32'd0);
    alu("add_wrap", 4'd0, 32'hFFFFFFFF, 32'd1, 32'd0);
    chk("add_wrap_zero", {31'd0, bus.zero}, 32'd1);
    alu("sub", 4'd1, 32'd3, 32'd5, 32'hFFFFFFFE);
    chk("sub_zero", {31'd0, bus.zero}, 32'd0);
    alu("and", 4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0);
    alu("or", 4'd3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0);
    alu("xor", 4'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00);
    alu("nor", 4'd5, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F);
    alu("sll", 4'd8, 32'd4, 32'd1, 32'd16);
    alu("srl", 4'd9, 32'd4, 32'h80000000, 32'h08000000);
    alu("sra", 4'd10, 32'd4, 32'h80000000, 32'hF8000000);
    alu("op13_add", 4'd13, 32'd2, 32'd3, 32'd5);
    set_in(1'b1, 4'd11, 32'd0, 32'hDEAD, 32'h1234, 1'b1, 5'b10000, 32'd0, 5'd2);
    tick();
    chk("lui", bus.oALU, 32'h12340000);
    chk("lui_bdatout", bus.Bdatout, 32'hDEAD);

    // Bubble with control bits set on the inputs.
    set_in(1'b0, 4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'b11111, 32'd0, 5'd9);
    tick();
    chk("bubble_valid", {31'd0, bus.valid_out}, 32'd0);
    chk("bubble_ctrl", {27'd0, bus.WriteRegout, bus.MemToRegout, bus.WriteMemout,
                        bus.MemReadout, bus.Branchout}, 32'd0);
    chk("bubble_oALU", bus.oALU, 32'd0);

    run_mul("mul_neg", 32'd7, 32'hFFFFFFFD, 32'd0, 1'b0, 5'd9, 32'hFFFFFFEB, 1'b0);
    run_mul("mul_ovf", 32'h10000, 32'h5, 32'h10000, 1'b1, 5'd11, 32'd0, 1'b1);

    // Flush at BUSY cycle 10.
    set_in(1'b1, 4'd12, 32'd3, 32'd3, 32'd0, 1'b0, 5'b10000, 32'd0, 5'd12);
    for (int i = 0; i < 10; i++) tick();
    chk("pre_flush_stall", {31'd0, bus.stall}, 32'd1);
    bus.flush = 1'b1;
    #1;
    chk("flush_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    chk("flush_bubble", {31'd0, bus.valid_out}, 32'd0);
    bus.flush = 1'b0;
    set_in(1'b1, 4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'b10000, 32'd0, 5'd13);
    tick();
    chk("post_flush_add", bus.oALU, 32'd2);
    chk("post_flush_regW", {27'd0, bus.regWout}, 32'd13);
    idle_in();
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.valid_out) vcnt++;
    end
    chk("flush_no_result", vcnt, 0);

    // Back-to-back MUL, MUL, ADD with an upstream that holds while stalled.
    b2b_op = '{4'd12, 4'd12, 4'd0};
    b2b_a  = '{32'd3, 32'd6, 32'd10};
    b2b_b  = '{32'd5, 32'd7, 32'd11};
    b2b_rw = '{5'd4, 5'd5, 5'd6};
    idx = 0;
    nres = 0;
    for (int k = 0; k < 90; k++) begin
      if (idx < 3) set_in(1'b1, b2b_op[idx], b2b_a[idx], b2b_b[idx], 32'd0, 1'b0,
                          5'b10000, 32'd0, b2b_rw[idx]);
      else idle_in();
      #1;
      st = bus.stall;
      tick();
      if (bus.valid_out && nres < 3) begin
        res_edge[nres] = k;
        res_alu[nres]  = bus.oALU;
        res_rw[nres]   = bus.regWout;
        nres++;
      end
      if (!st && idx < 3) idx++;
    end
    chk("b2b_count", nres, 3);
    if (nres == 3) begin
      chk("b2b_edge0", res_edge[0], 33);
      chk("b2b_edge1", res_edge[1], 67);
      chk("b2b_edge2", res_edge[2], 68);
      chk("b2b_alu0", res_alu[0], 32'd15);
      chk("b2b_alu1", res_alu[1], 32'd42);
      chk("b2b_alu2", res_alu[2], 32'd21);
      chk("b2b_rw0", {27'd0, res_rw[0]}, 32'd4);
      chk("b2b_rw1", {27'd0, res_rw[1]}, 32'd5);
      chk("b2b_rw2", {27'd0, res_rw[2]}, 32'd6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage pipeline, sitting between the ID/EX register and the MEM stage. It selects ALU operands, computes the ALU result, the zero flag and the branch target, and registers them with the pass-through control bits into the EX/MEM register consumed by MEM. It also provides a 32-cycle iterative multiply (MUL) that stalls upstream while it runs. A flush from branch resolution kills in-flight work.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- clk  in  1  single pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ID/EX holds a real instruction
- WriteReg, MemToReg, WriteMem, MemRead, Branch  in  1 each  control bits from ID
- ALUSrc  in  1  1: operand B = imm, 0: operand B = Bdat
- ALUop  in  4  operation select (encoding below)
- pc_plus4  in  32  PC+4 of the instruction
- Adat, Bdat  in  32  register-file read data
- imm  in  32  sign-extended immediate
- regW  in  5  destination register index
- flush  in  1  kill the current instruction and any MUL in progress
- stall  out  1  upstream must hold all inputs stable while high
- valid_out  out  1  EX/MEM slot holds a real instruction
- WriteRegout, MemToRegout, WriteMemout, MemReadout, Branchout  out  1 each  registered control
- pcplusimm  out  32  branch target
- zero  out  1  registered zero flag
- oALU  out  32  registered ALU result / memory address
- Bdatout  out  32  registered store data (raw Bdat, never imm)
- regWout  out  5  registered destination index

## Operation
- Operands: A = Adat; B = ALUSrc ? imm : Bdat.
- ALUop: 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR; 5 NOR; 6 SLT (signed, result 0/1); 7 SLTU; 8 SLL (B << A[4:0]); 9 SRL; 10 SRA (arithmetic); 11 LUI (B << 16); 12 MUL (low 32 bits of A*B); 13-15 behave as ADD.
- All arithmetic mod 2^32, overflow ignored. zero = (result == 0). pcplusimm = pc_plus4 + (imm << 2), mod 2^32.
- Bubble: valid_out=0, all five control outs 0; data outs don't-care but must be 0.
- FSM states IDLE, BUSY, DONE; 5-bit step counter; 32-bit multiplicand, multiplier and accumulator registers; latched copy of control, regW, Bdat, pc_plus4, imm.
- IDLE, in_valid=1, ALUop!=12: EX/MEM loads result at next edge; stall=0.
- IDLE, in_valid=0: EX/MEM loads bubble.
- IDLE, in_valid=1, ALUop=12: stall=1 combinationally; latch operands/control; acc=0, cnt=0; EX/MEM loads bubble; go BUSY.
- BUSY: stall=1; one shift-add step per cycle (if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1); EX/MEM loads bubble; after step with cnt=31 go DONE, else cnt++.
- DONE: stall=0; EX/MEM loads latched control, oALU=acc, zero=(acc==0), valid_out=1; go IDLE. Live inputs (still the held MUL) are ignored in DONE.
- flush=1 (any state): EX/MEM loads bubble, FSM to IDLE, cnt=0, stall=0 that cycle; higher priority than all but reset.

## Timing
- Reset (rst_n=0, asynchronous): all outputs 0, valid_out=0, state IDLE, cnt 0, stall 0. Reset mid-MUL aborts without a result.
- Single-cycle ops: inputs at cycle t, outputs valid after edge t (latency 1).
- MUL accepted at cycle t: stall high cycles t..t+32 (33 cycles), bubbles after edges t..t+32, result after edge t+33; upstream advances at edge t+33.
- Back-to-back MULs: second accepted in IDLE the cycle after DONE; no gap otherwise.
- stall never depends on flush from the same cycle except being forced 0 by it.

## Test plan
- Reset: assert rst_n=0 mid-stream -> all outputs 0 immediately, stall=0; release -> first ADD 3+4 gives oALU=7 one edge later.
- Branch: ALUop=1, Adat=5, Bdat=5, Branch=1, pc_plus4=0x100, imm=3 -> zero=1, pcplusimm=0x10C, Branchout=1.
- ALU sweep: A=0xFFFFFFFF, B=1 -> SLT=1, SLTU=0, ADD=0 with zero=1; SRA by 4 of 0x80000000 -> 0xF8000000; LUI imm=0x1234, ALUSrc=1 -> 0x12340000; Bdatout equals Bdat, not imm.
- MUL: 7 × 0xFFFFFFFD -> stall high exactly 33 cycles, 33 bubbles, then oALU=0xFFFFFFEB, zero=0; 0x10000 × 0x10000 -> oALU=0, zero=1.
- Flush at BUSY cycle 10 -> bubble out, stall drops same cycle, next ADD accepted normally; no MUL result ever appears.
- Back-to-back MUL, MUL, ADD -> results emerge at edges t+33, t+67, t+68 in order with correct regWout.
